// File: rtl/port_dev.sv
// Peripheral endpoint on a shared bidirectional bus: answers CPU reads from a
// small TX FIFO and captures CPU writes into an RX holding register.
module port_dev #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  inout  wire  [WIDTH-1:0]           port,
  input  logic                       cpu_drv,
  input  logic                       cpu_rd,
  input  logic [WIDTH-1:0]           tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [WIDTH-1:0]           rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshakes: tx side accepts a word on an edge where tx_valid & tx_ready;
  // rx side hands over a word on an edge where rx_valid & rx_ready.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] stage;
  logic             drv_q;
  logic             rd_q;
  logic             rd_eff;
  logic             push;
  logic             pop;
  logic             commit;
  logic             not_empty;

  // A CPU write always wins over a simultaneous read strobe.
  assign rd_eff    = cpu_rd & ~cpu_drv;
  assign not_empty = (count != '0);
  assign tx_ready  = (count != CW'(DEPTH));
  assign push      = tx_valid & tx_ready;
  assign pop       = rd_q & ~rd_eff & not_empty;
  assign commit    = drv_q & ~cpu_drv;

  assign port = rd_eff ? (not_empty ? mem[rd_ptr] : '0) : {WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stage    <= '0;
      drv_q    <= 1'b0;
      rd_q     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      drv_q <= cpu_drv;
      rd_q  <= rd_eff;

      if (push) begin
        mem[wr_ptr] <= tx_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Last driven value wins; it is only published when the drive ends.
      if (cpu_drv) begin
        stage <= port;
      end

      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= stage;
          rx_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_port_dev.sv
// Bench for port_dev: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the device.
module tb_port_dev;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  wire  [WIDTH-1:0] port;
  logic             cpu_drv;
  logic             cpu_rd;
  logic             cpu_oe;
  logic [WIDTH-1:0] cpu_bus;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [2:0]       count;
  logic             overflow;

  assign port = cpu_oe ? cpu_bus : {WIDTH{1'bz}};

  port_dev #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .port(port), .cpu_drv(cpu_drv), .cpu_rd(cpu_rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .count(count), .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard and reference model state
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_stage, m_rx_data;
  bit               m_rx_valid, m_ovf, m_prev_rd, m_prev_drv;
  logic [WIDTH-1:0] last_port;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A released bus reads as 0 here regardless of how the simulator resolves Z.
  function automatic logic [WIDTH-1:0] seen_port();
    logic [WIDTH-1:0] s;
    for (int i = 0; i < WIDTH; i++) s[i] = (port[i] === 1'b1);
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] exp_port();
    if (cpu_drv) return cpu_bus;
    if (cpu_rd) return (exp_q.size() > 0) ? exp_q[0] : '0;
    return '0;
  endfunction

  task automatic model_edge();
    int sz;
    bit rd_now;
    sz = exp_q.size();
    rd_now = cpu_rd && !cpu_drv;
    if (rst) begin
      exp_q.delete();
      m_stage = '0; m_rx_data = '0; m_rx_valid = 0; m_ovf = 0;
      m_prev_rd = 0; m_prev_drv = 0;
    end else begin
      if (m_prev_rd && !rd_now && sz > 0) void'(exp_q.pop_front());
      if (tx_valid && sz < DEPTH) exp_q.push_back(tx_data);
      if (m_prev_drv && !cpu_drv) begin
        if (!m_rx_valid || rx_ready) begin
          m_rx_data = m_stage;
          m_rx_valid = 1;
        end else begin
          m_ovf = 1;
        end
      end else if (m_rx_valid && rx_ready) begin
        m_rx_valid = 0;
      end
      if (cpu_drv) m_stage = cpu_bus;
      m_prev_rd = rd_now;
      m_prev_drv = cpu_drv;
    end
  endtask

  // driver: apply one cycle of inputs starting at a falling edge
  task automatic step(input bit r, input bit d, input bit rd, input logic [WIDTH-1:0] b,
                      input bit tv, input logic [WIDTH-1:0] td, input bit rr);
    rst = r; cpu_drv = d; cpu_oe = d; cpu_bus = b; cpu_rd = rd;
    tx_valid = tv; tx_data = td; rx_ready = rr;
    #1;
    last_port = seen_port();
    check_eq("port", last_port, exp_port());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("count", count, exp_q.size());
    check_eq("tx_ready", tx_ready, exp_q.size() != DEPTH);
    check_eq("rx_valid", rx_valid, m_rx_valid);
    check_eq("rx_data", rx_data, m_rx_data);
    check_eq("overflow", overflow, m_ovf);
  endtask

  task automatic idle(input bit rr = 0);
    step(0, 0, 0, 8'h00, 0, 8'h00, rr);
  endtask

  initial begin
    bit d, rd;
    logic [WIDTH-1:0] vals [4];
    rst = 1; cpu_drv = 0; cpu_oe = 0; cpu_bus = '0; cpu_rd = 0;
    tx_valid = 0; tx_data = '0; rx_ready = 0;
    m_stage = '0; m_rx_data = '0; m_rx_valid = 0; m_ovf = 0;
    m_prev_rd = 0; m_prev_drv = 0;
    @(negedge clk);
    step(1, 0, 0, 8'h00, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0, 8'h00, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_rx_valid", rx_valid, 0);

    // single push then single-cycle read
    step(0, 0, 0, 8'h00, 1, 8'hAC, 0);
    check_eq("t1_count_push", count, 1);
    step(0, 0, 1, 8'h00, 0, 8'h00, 0);
    check_eq("t1_port", last_port, 8'hAC);
    check_eq("t1_count_during", count, 1);
    idle();
    check_eq("t1_count_after", count, 0);
    check_eq("t1_port_after", last_port, 8'h00);

    // long write gives exactly one commit
    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'hDC, 0, 8'h00, 0);
    check_eq("t2_no_early_commit", rx_valid, 0);
    idle();
    check_eq("t2_rx_data", rx_data, 8'hDC);
    check_eq("t2_rx_valid", rx_valid, 1);
    idle(); idle();
    check_eq("t2_rx_held", rx_valid, 1);
    idle(1);
    check_eq("t2_rx_cleared", rx_valid, 0);

    // fill, refuse a fifth push, drain in order, read empty
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1, vals[i], 0);
    check_eq("t3_full_count", count, 4);
    check_eq("t3_full_ready", tx_ready, 0);
    step(0, 0, 0, 8'h00, 1, 8'h55, 0);
    check_eq("t3_refused", count, 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 8'h00, 0, 8'h00, 0);
      check_eq("t3_read", last_port, vals[i]);
      idle();
    end
    step(0, 0, 1, 8'h00, 0, 8'h00, 0);
    check_eq("t3_empty_read", last_port, 8'h00);
    idle();
    check_eq("t3_empty_count", count, 0);

    // overflow on back-to-back commits without consumer
    step(0, 1, 0, 8'hAB, 0, 8'h00, 0); idle();
    step(0, 1, 0, 8'hDE, 0, 8'h00, 0); idle();
    check_eq("t4_kept", rx_data, 8'hAB);
    check_eq("t4_ovf", overflow, 1);
    idle(1);
    step(0, 1, 0, 8'hAB, 0, 8'h00, 0); idle();
    step(0, 1, 0, 8'hDE, 0, 8'h00, 0); idle(1);
    check_eq("t4_replaced", rx_data, 8'hDE);
    check_eq("t4_valid", rx_valid, 1);
    check_eq("t4_ovf_sticky", overflow, 1);
    idle(1);

    // simultaneous read and write is a write only
    step(0, 0, 0, 8'h00, 1, 8'h5A, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 8'h21, 0, 8'h00, 0);
      check_eq("t5_bus", last_port, 8'h21);
    end
    idle();
    check_eq("t5_count", count, 1);
    check_eq("t5_commit", rx_data, 8'h21);

    // reset during a read and during a write
    step(0, 0, 0, 8'h00, 1, 8'h66, 0);
    step(0, 0, 1, 8'h00, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0, 8'h00, 0);
    step(0, 1, 0, 8'h77, 0, 8'h00, 0);
    step(0, 1, 0, 8'h77, 0, 8'h00, 0);
    step(1, 1, 0, 8'h77, 0, 8'h00, 0);
    step(1, 1, 0, 8'h77, 0, 8'h00, 0);
    idle(); idle();
    check_eq("t6_count", count, 0);
    check_eq("t6_tx_ready", tx_ready, 1);
    check_eq("t6_rx_valid", rx_valid, 0);
    check_eq("t6_rx_data", rx_data, 0);
    check_eq("t6_ovf", overflow, 0);

    // randomized traffic with strobes held for random lengths
    d = 0; rd = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) d = ~d;
      if ($urandom_range(0, 2) == 0) rd = ~rd;
      step($urandom_range(0, 79) == 0, d, rd, WIDTH'($urandom),
           $urandom_range(0, 1) == 1, WIDTH'($urandom), $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
